// File: rtl/router_pkg.sv
// Shared types and default sizes for the router input port.
package router_pkg;

  localparam int FLIT_WIDTH   = 16;
  localparam int BUFFER_DEPTH = 16;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  // Packet framing phases of one input port.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HEADER,
    S_SIZE,
    S_PAYLOAD
  } ibuf_state_t;

endpackage

// File: rtl/router_input_buffer_credit_fifo.sv
// Credit-based flit FIFO: storage, wrapping pointers, occupancy count and
// the upstream credit signal derived from the occupancy.
module credit_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx,
  input  logic [W-1:0]             data_i,
  input  logic                     pop,
  output logic                     credit_o,
  output logic [W-1:0]             data_o,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  // Occupancy flags and credit; credit is held low while reset is asserted.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    credit_o = reset && !full;
    wr_en    = rx && credit_o;
    rd_en    = pop && !empty;
    data_o   = mem[rd_ptr];
  end

  // Flit storage; contents are not reset, only the pointers are.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_input_buffer.sv
// Router input port: buffers incoming flits, requests a route for the header
// at the FIFO head, then streams header, size and payload to the crossbar.
//
// Handshakes: upstream flit accepted on a rising edge when rx && credit_o;
// crossbar flit taken when data_av && data_ack; routing grant is a single
// cycle ack_h pulse honoured only while h is high.
module router_input_buffer
  import router_pkg::*;
#(
  parameter int FLIT_WIDTH   = router_pkg::FLIT_WIDTH,
  parameter int BUFFER_DEPTH = router_pkg::BUFFER_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx,
  input  logic [FLIT_WIDTH-1:0]         data_i,
  output logic                          credit_o,
  output logic                          h,
  input  logic                          ack_h,
  output logic                          data_av,
  output logic [FLIT_WIDTH-1:0]         data_o,
  input  logic                          data_ack,
  output logic                          sender,
  output ibuf_state_t                   dbg_state,
  output logic [$clog2(BUFFER_DEPTH):0] dbg_count
);

  ibuf_state_t           state;
  ibuf_state_t           state_next;
  logic [FLIT_WIDTH-1:0] remaining;
  logic                  empty;
  logic                  pop;

  credit_fifo #(
    .W     (FLIT_WIDTH),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .data_i   (data_i),
    .pop      (pop),
    .credit_o (credit_o),
    .data_o   (data_o),
    .empty    (empty),
    .count    (dbg_count)
  );

  assign pop       = data_av && data_ack;
  assign dbg_state = state;

  // State register and payload down-counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
    end else begin
      state <= state_next;
      if (pop && state == S_SIZE)    remaining <= data_o;
      if (pop && state == S_PAYLOAD) remaining <= remaining - FLIT_WIDTH'(1);
    end
  end

  // Next-state: framing advances only on the grant or on actual pops.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!empty) state_next = S_REQ;
      S_REQ:     if (ack_h)  state_next = S_HEADER;
      S_HEADER:  if (pop)    state_next = S_SIZE;
      S_SIZE:    if (pop)    state_next = (data_o == '0) ? S_IDLE : S_PAYLOAD;
      S_PAYLOAD: if (pop && remaining == FLIT_WIDTH'(1)) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode from the current framing phase.
  always_comb begin
    h       = 1'b0;
    data_av = 1'b0;
    sender  = 1'b0;
    case (state)
      S_REQ:     h = 1'b1;
      S_HEADER:  begin sender = 1'b1; data_av = 1'b1;   end
      S_SIZE:    begin sender = 1'b1; data_av = !empty; end
      S_PAYLOAD: begin sender = 1'b1; data_av = !empty; end
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_router_input_buffer.sv
// Directed bench for router_input_buffer with a packet-level reference model.
module tb_router_input_buffer;
  import router_pkg::*;

  localparam int W  = 16;
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;

  // clock / reset block
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          rx = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          ack_h = 1'b0;
  logic          data_ack = 1'b0;
  logic          credit_o, h, data_av, sender;
  logic [W-1:0]  data_o;
  ibuf_state_t   dbg_state;
  logic [CW-1:0] dbg_count;

  router_input_buffer dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data_i    (data_i),
    .credit_o  (credit_o),
    .h         (h),
    .ack_h     (ack_h),
    .data_av   (data_av),
    .data_o    (data_o),
    .data_ack  (data_ack),
    .sender    (sender),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of accepted flits plus packet progress
  logic [W-1:0] mq[$];
  bit           m_req = 0;
  bit           m_active = 0;
  int           m_pos = 0;
  int           m_left = 0;

  // scoreboard
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tx_q[$];
  int           sender_cycles = 0;
  int           h_during_sender = 0;

  // compare process: checks every cycle shortly before the rising edge,
  // then advances the model with the inputs that edge will see
  initial begin
    bit           exp_credit, exp_av, idle_pre;
    int           n_pre;
    logic [W-1:0] f;
    forever begin
      @(negedge clock);
      #3;
      if (!reset) begin
        mq.delete();
        m_req = 0; m_active = 0; m_pos = 0; m_left = 0;
        check("rst_credit", credit_o, 0);
        check("rst_h", h, 0);
        check("rst_data_av", data_av, 0);
        check("rst_sender", sender, 0);
      end else begin
        exp_credit = (mq.size() < BUFFER_DEPTH);
        exp_av     = m_active && (mq.size() > 0);
        check("credit", credit_o, exp_credit);
        check("h", h, m_req);
        check("sender", sender, m_active);
        check("data_av", data_av, exp_av);
        check("count", dbg_count, mq.size());
        if (exp_av) check("data_o", data_o, mq[0]);
        if (sender) sender_cycles++;
        if (h && sender) h_during_sender++;
        if (data_av && data_ack) got_q.push_back(data_o);

        idle_pre = !m_active && !m_req;
        n_pre    = mq.size();
        if (exp_av && data_ack) begin
          f = mq.pop_front();
          if (m_pos == 0) begin
            m_pos = 1;
          end else if (m_pos == 1) begin
            m_pos  = 2;
            m_left = int'(f);
            if (m_left == 0) m_active = 0;
          end else begin
            m_left--;
            if (m_left == 0) m_active = 0;
          end
        end
        if (m_req && ack_h) begin
          m_req = 0; m_active = 1; m_pos = 0;
        end else if (idle_pre && n_pre > 0) begin
          m_req = 1;
        end
        if (rx && exp_credit) mq.push_back(data_i);
      end
    end
  end

  // routing arbiter stand-in: grants ack_delay cycles after h rises
  int ack_delay = 2;
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clock);
      #1;
      ack_h = 1'b0;
      if (h && reset) begin
        if (cnt == ack_delay) begin
          ack_h = 1'b1;
          cnt   = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic push_all();
    while (tx_q.size() > 0) begin
      @(negedge clock);
      #1;
      rx     = 1'b1;
      data_i = tx_q.pop_front();
    end
    @(negedge clock);
    #1;
    rx = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clock);
      #4;
      n++;
    end while (!(dbg_state == S_IDLE && dbg_count == '0 && !sender) && n < budget);
    check({name, "_timeout"}, (n < budget), 1);
  endtask

  task automatic check_got(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check($sformatf("%s_flit%0d", name, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int n;

    // 1: reset held 3 cycles
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    #4;
    check("t1_credit", credit_o, 1);
    check("t1_h", h, 0);
    check("t1_data_av", data_av, 0);
    check("t1_sender", sender, 0);

    // 2: basic packet, data_ack held high
    got_q.delete();
    sender_cycles = 0;
    data_ack = 1'b1;
    tx_q  = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
    exp_q = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
    push_all();
    wait_idle(60, "t2");
    check_got("t2");
    check("t2_sender_cycles", sender_cycles, 4);
    check("t2_state", dbg_state, S_IDLE);

    // 3: fill to full, drop 17th, pop one, push+pop together
    got_q.delete();
    data_ack = 1'b0;
    exp_q.delete();
    tx_q = '{16'h0100, 16'h000F};
    exp_q = '{16'h0100, 16'h000F};
    for (int i = 1; i <= 14; i++) begin
      tx_q.push_back(16'h1000 + 16'(i));
      exp_q.push_back(16'h1000 + 16'(i));
    end
    tx_q.push_back(16'hDEAD);
    exp_q.push_back(16'h100F);
    push_all();
    @(negedge clock);
    #4;
    check("t3_full_count", dbg_count, 16);
    check("t3_full_credit", credit_o, 0);
    n = 0;
    while (dbg_state != S_HEADER && n < 20) begin
      @(negedge clock);
      #4;
      n++;
    end
    check("t3_header_timeout", (n < 20), 1);
    @(negedge clock);
    #1 data_ack = 1'b1;
    @(negedge clock);
    #2;
    check("t3_credit_back", credit_o, 1);
    check("t3_count_15", dbg_count, 15);
    rx = 1'b1;
    data_i = 16'h100F;
    @(negedge clock);
    #2;
    check("t3_push_pop_stable", dbg_count, 15);
    rx = 1'b0;
    wait_idle(80, "t3");
    check_got("t3");

    // 4: zero-size packet followed by a one-flit packet
    got_q.delete();
    tx_q  = '{16'h0022, 16'h0000, 16'h0033, 16'h0001, 16'h0044};
    exp_q = '{16'h0022, 16'h0000, 16'h0033, 16'h0001, 16'h0044};
    push_all();
    wait_idle(60, "t4");
    check_got("t4");

    // 5: back-to-back packets, second queued behind the first
    got_q.delete();
    h_during_sender = 0;
    tx_q  = '{16'h0055, 16'h0001, 16'h0066, 16'h0077, 16'h0001, 16'h0088};
    exp_q = '{16'h0055, 16'h0001, 16'h0066, 16'h0077, 16'h0001, 16'h0088};
    push_all();
    wait_idle(80, "t5");
    check_got("t5");
    check("t5_h_during_sender", h_during_sender, 0);

    // 6: reset after two of five payload flits, then a fresh packet
    got_q.delete();
    ack_delay = 4;
    tx_q = '{16'h0099, 16'h0005, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005};
    push_all();
    n = 0;
    while (got_q.size() < 4 && n < 40) begin
      @(negedge clock);
      #4;
      n++;
    end
    check("t6_progress_timeout", (n < 40), 1);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("t6_h", h, 0);
    check("t6_data_av", data_av, 0);
    check("t6_sender", sender, 0);
    check("t6_credit", credit_o, 0);
    check("t6_count", dbg_count, 0);
    exp_q = '{16'h0099, 16'h0005, 16'hC001, 16'hC002};
    check_got("t6_before_reset");
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    got_q.delete();
    ack_delay = 2;
    tx_q  = '{16'h00AA, 16'h0001, 16'h00BB};
    exp_q = '{16'h00AA, 16'h0001, 16'h00BB};
    push_all();
    wait_idle(60, "t6");
    check_got("t6_after_reset");

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
